// File: rtl/icache_pkg.sv
// Shared types for the instruction cache.
// icachef_t      : byte-address split for the 16-set geometry {tag, idx, bytoff}
// icache_frame_t : one cache frame {valid, tag, data} for the 16-set geometry
// icache_state_t : fill controller state
package icache_pkg;

  typedef struct packed {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  bytoff;
  } icachef_t;

  typedef struct packed {
    logic        valid;
    logic [25:0] tag;
    logic [31:0] data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Instruction-side bus between the fetch stage, the icache and the memory controller.
// Datapath half : imemREN, imemaddr (to cache), ihit, imemload (from cache)
// Memory half   : iREN, iaddr (from cache), iwait, iload (to cache)
// slave  modport: the cache
// master modport: the agent driving the datapath requests and the memory responses
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with single-word fill.
// Ports:
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset (clears valid bits, FSM, miss address)
//   cif  : icache_if.slave, datapath request/response plus memory read port
// Parameter SETS: number of frames, power of two in 2..256.
//
// state | meaning
// IDLE  | lookup; combinational hit, miss latches {tag,idx} and starts a fill
// FILL  | memory read of miss_addr; completes on the first cycle iwait is low
module icache
  import icache_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input logic     CLK,
  input logic     nRST,
  icache_if.slave cif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  icache_state_t state_q, state_d;
  logic [29:0]   miss_q, miss_d;
  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             match;
  logic             fill_done;
  logic [1:0]       unused_bytoff;

  assign req_idx       = cif.imemaddr[IDX_W+1:2];
  assign req_tag       = cif.imemaddr[31:IDX_W+2];
  assign unused_bytoff = cif.imemaddr[1:0];
  assign miss_idx      = miss_q[IDX_W-1:0];
  assign miss_tag      = miss_q[29:IDX_W];

  assign match     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_done = (state_q == FILL) && !cif.iwait;

  // State, miss address and valid bits: reset clears all, dropping any fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      if (fill_done) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are qualified by valid, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= cif.iload;
    end
  end

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    case (state_q)
      IDLE: begin
        if (cif.imemREN && !match) begin
          state_d = FILL;
          miss_d  = cif.imemaddr[31:2];
        end
      end
      FILL: begin
        // Address redirects and imemREN drops do not cancel the fill.
        if (!cif.iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    case (state_q)
      IDLE: begin
        cif.ihit = cif.imemREN && match;
        if (match) cif.imemload = data_q[req_idx];
      end
      FILL: begin
        cif.iREN  = 1'b1;
        cif.iaddr = {miss_q, 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;
  import icache_pkg::*;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        chk_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vt[$];

  icache_if cif ();

  icache #(.SETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .cif  (cif.slave)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic ren, logic [31:0] addr, logic wt, logic [31:0] ld,
                              logic e_hit, logic [31:0] e_load, logic chk_load,
                              logic e_ren, logic [31:0] e_iaddr);
    vec_t v;
    v.ren = ren; v.addr = addr; v.wt = wt; v.ld = ld;
    v.e_hit = e_hit; v.e_load = e_load; v.chk_load = chk_load;
    v.e_ren = e_ren; v.e_iaddr = e_iaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic wt,
                       input logic [31:0] ld);
    cif.imemREN  = ren;
    cif.imemaddr = addr;
    cif.iwait    = wt;
    cif.iload    = ld;
  endtask

  // Called 1 time unit after a rising edge; checks mid-cycle, returns 1 after the next edge.
  task automatic step(input string tagname, input vec_t v);
    drive(v.ren, v.addr, v.wt, v.ld);
    #3;
    chk({tagname, ".ihit"}, {31'd0, cif.ihit}, {31'd0, v.e_hit});
    if (v.chk_load) chk({tagname, ".imemload"}, cif.imemload, v.e_load);
    chk({tagname, ".iREN"}, {31'd0, cif.iREN}, {31'd0, v.e_ren});
    chk({tagname, ".iaddr"}, cif.iaddr, v.e_iaddr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // ---- reset with a pending request ----
    nRST = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.ihit", {31'd0, cif.ihit}, 32'd0);
    chk("rst.iREN", {31'd0, cif.iREN}, 32'd0);
    chk("rst.iaddr", cif.iaddr, 32'd0);
    chk("rst.imemload", cif.imemload, 32'd0);
    nRST = 1'b1;
    step("rel0", mk(1, 32'h0, 1, 0, 0, 0, 1, 0, 32'h0));
    step("rel1", mk(1, 32'h0, 0, 32'h1111_1111, 0, 0, 1, 1, 32'h0));
    step("rel2", mk(1, 32'h0, 1, 0, 1, 32'h1111_1111, 1, 0, 32'h0));

    // ---- directed vector table ----
    // cold miss on 0x40 (index 0, tag 1), three wait cycles
    vt.push_back(mk(1, 32'h40, 1, 0,            0, 0,            1, 0, 32'h0));
    vt.push_back(mk(1, 32'h40, 1, 0,            0, 0,            1, 1, 32'h40));
    vt.push_back(mk(1, 32'h40, 1, 0,            0, 0,            1, 1, 32'h40));
    vt.push_back(mk(1, 32'h40, 1, 0,            0, 0,            1, 1, 32'h40));
    vt.push_back(mk(1, 32'h40, 0, 32'h8C220004, 0, 0,            1, 1, 32'h40));
    vt.push_back(mk(1, 32'h40, 1, 0,            1, 32'h8C220004, 1, 0, 32'h0));
    vt.push_back(mk(1, 32'h40, 1, 0,            1, 32'h8C220004, 1, 0, 32'h0));
    // conflict: 0x80 evicts frame 0, then 0x40 misses again
    vt.push_back(mk(1, 32'h80, 1, 0,            0, 0,            1, 0, 32'h0));
    vt.push_back(mk(1, 32'h80, 0, 32'hAAAA0080, 0, 0,            1, 1, 32'h80));
    vt.push_back(mk(1, 32'h80, 1, 0,            1, 32'hAAAA0080, 1, 0, 32'h0));
    vt.push_back(mk(1, 32'h40, 1, 0,            0, 0,            1, 0, 32'h0));
    vt.push_back(mk(1, 32'h40, 0, 32'h8C220004, 0, 0,            1, 1, 32'h40));
    vt.push_back(mk(1, 32'h40, 1, 0,            1, 32'h8C220004, 1, 0, 32'h0));
    // redirect mid-fill: miss on 0x100, address moves to 0x204 during the fill
    vt.push_back(mk(1, 32'h100, 1, 0,            0, 0,            1, 0, 32'h0));
    vt.push_back(mk(1, 32'h204, 1, 0,            0, 0,            1, 1, 32'h100));
    vt.push_back(mk(1, 32'h204, 1, 0,            0, 0,            1, 1, 32'h100));
    vt.push_back(mk(1, 32'h204, 0, 32'h0BAD0100, 0, 0,            1, 1, 32'h100));
    vt.push_back(mk(1, 32'h204, 1, 0,            0, 0,            1, 0, 32'h0));
    vt.push_back(mk(1, 32'h204, 0, 32'h12340204, 0, 0,            1, 1, 32'h204));
    vt.push_back(mk(1, 32'h204, 1, 0,            1, 32'h12340204, 1, 0, 32'h0));
    vt.push_back(mk(1, 32'h100, 1, 0,            1, 32'h0BAD0100, 1, 0, 32'h0));
    // no hit in FILL even when the address matches valid frame 1; imemREN low does not abort
    vt.push_back(mk(1, 32'h40,  1, 0,            0, 0,            1, 0, 32'h0));
    vt.push_back(mk(1, 32'h204, 1, 0,            0, 0,            0, 1, 32'h40));
    vt.push_back(mk(0, 32'h204, 0, 32'h8C220004, 0, 0,            0, 1, 32'h40));
    vt.push_back(mk(1, 32'h40,  1, 0,            1, 32'h8C220004, 1, 0, 32'h0));
    // miss address with imemREN low does not start a fill; matching frame still drives imemload
    vt.push_back(mk(0, 32'h300, 1, 0,            0, 0,            1, 0, 32'h0));
    vt.push_back(mk(0, 32'h300, 1, 0,            0, 0,            1, 0, 32'h0));
    vt.push_back(mk(0, 32'h40,  1, 0,            0, 32'h8C220004, 1, 0, 32'h0));

    for (int i = 0; i < vt.size(); i++) step($sformatf("vec%0d", i), vt[i]);

    // ---- asynchronous reset while filling ----
    step("ar0", mk(1, 32'h300, 1, 0, 0, 0, 1, 0, 32'h0));
    step("ar1", mk(1, 32'h300, 1, 0, 0, 0, 1, 1, 32'h300));
    nRST = 1'b0;
    #1;
    chk("ar.iREN_async", {31'd0, cif.iREN}, 32'd0);
    chk("ar.iaddr_async", cif.iaddr, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step("ar2", mk(1, 32'h40, 1, 0,            0, 0,            1, 0, 32'h0));
    step("ar3", mk(1, 32'h40, 0, 32'h8C220004, 0, 0,            1, 1, 32'h40));
    step("ar4", mk(1, 32'h40, 1, 0,            1, 32'h8C220004, 1, 0, 32'h0));

    // ---- sequential fetch 0x0..0x3C, first pass misses, second pass hits ----
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = i * 4;
      d = 32'hC0DE_0000 | i;
      step($sformatf("seq1m%0d", i), mk(1, a, 0, d, 0, 0, 1, 0, 32'h0));
      step($sformatf("seq1f%0d", i), mk(1, a, 0, d, 0, 0, 1, 1, a));
      step($sformatf("seq1h%0d", i), mk(1, a, 0, 0, 1, d, 1, 0, 32'h0));
    end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = i * 4;
      d = 32'hC0DE_0000 | i;
      step($sformatf("seq2h%0d", i), mk(1, a, 0, 0, 1, d, 1, 0, 32'h0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that is the responder on the instruction half of `datapath_cache_if`. It sits between the pipelined datapath's fetch stage and the memory controller. It answers `imemREN`/`imemaddr` with `ihit`/`imemload`. On a miss it runs a single-word fill over the memory-side instruction port (`iREN`/`iaddr`/`iwait`/`iload`).

## Interface
- `SETS`, 16: number of frames; power of two, 2..256; index width `IDX_W = $clog2(SETS)`
- `CLK`  in  1  system clock, all state on rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `imemREN`  in  1  datapath instruction read request
- `imemaddr`  in  32  instruction byte address; bits [1:0] ignored
- `ihit`  out  1  `imemload` valid for current `imemaddr` this cycle
- `imemload`  out  32  instruction word
- `iREN`  out  1  memory-side read request
- `iaddr`  out  32  memory-side word address (bits [1:0] = 0)
- `iwait`  in  1  memory busy; read data not ready while high
- `iload`  in  32  memory read data, valid when `iREN && !iwait`

## Operation
- Address split: tag = [31:2+IDX_W], index = [1+IDX_W:2], byte offset = [1:0].
- Each frame holds a valid bit, a tag, and one 32-bit word.
- There is no write path and no flush. Frames change only by fill or by reset.
- FSM has two states: IDLE and FILL.
- IDLE:
  - `ihit = imemREN && valid[idx] && tag[idx]==addr.tag`.
  - `imemload = data[idx]` whenever the frame matches; otherwise 0.
  - If `imemREN` is high and there is no hit, latch `{tag,idx}` into `miss_addr` and go to FILL.
- FILL:
  - `iREN = 1`, `iaddr = {miss_addr, 2'b00}`, `ihit = 0`.
  - When `!iwait`, write `iload` into frame `miss_addr.idx`, set valid, set tag, and go to IDLE.
- Redirect mid-fill: if `imemaddr` changes during FILL (branch or jump cancel), the fill still completes for `miss_addr`. After return to IDLE, the new address is looked up normally.
- `imemREN` low during FILL does not abort the fill.
- `iREN` and `iaddr` are driven only from FSM state and `miss_addr`. They never come combinationally from `imemaddr`.

## Timing
- Hit latency: 0 cycles. `ihit` is combinational from `imemaddr`/`imemREN` in IDLE.
- Miss latency:
  - Cycle 0: miss detected.
  - Cycle 1 onward: FILL, with `iREN` high.
  - The fill completes on the edge where `iwait` is low.
  - `ihit` rises in the following cycle (IDLE).
  - Minimum miss penalty is 2 cycles of `ihit` low when `iwait` is low on the first FILL cycle.
- `ihit` is never high in FILL, even if `imemaddr` matches another valid frame.
- Reset (async, any state, including mid-FILL):
  - All valid bits cleared; state goes to IDLE; `miss_addr` = 0.
  - Outputs after reset: `iREN = 0`, `iaddr = 0`, `ihit = 0`, `imemload = 0`.
  - A partially complete fill is discarded.
- Frame data and tag arrays need not be reset; only the valid bits are.

## Structure
- `icachef_t` packed struct `{tag, idx, bytoff}`, sized for `SETS = 16` (26/4/2), goes in `cpu_types_pkg`.
- `icache_frame_t` `{valid, tag, data}` and the state enum `icache_state_t {IDLE, FILL}` also go in `cpu_types_pkg`.
- No sub-module. The frame array, FSM and `miss_addr` register live in one `always_ff` / `always_comb` pair.
- Top-level `caches` wrapper connects `dcif.ihit/imemload/imemREN/imemaddr` and `ccif.iREN/iaddr/iwait/iload`.

## Test plan
- Reset with `imemREN = 1`, `imemaddr = 0x0` → `ihit = 0` and `iREN = 0` during reset. One cycle after release, `iREN = 1`, `iaddr = 0x0`.
- Cold miss:
  - Stimulus: `imemaddr = 0x40` with `iwait` high 3 cycles, then low with `iload = 0x8C220004`.
  - Required: frame 0 filled; the next cycle shows `ihit = 1`, `imemload = 0x8C220004`.
  - A repeat access to `0x40` hits immediately with no `iREN`.
- Conflict:
  - Stimulus: fill `0x40`, then request `0x80` (same index 0, different tag).
  - Required: miss and refill of frame 0. A subsequent request to `0x40` misses again.
- Redirect mid-fill:
  - Stimulus: miss on `0x100`; change `imemaddr` to `0x204` while `iwait` is high.
  - Required: fill completes to `iaddr = 0x100`. `0x204` then misses, with `iaddr = 0x204`.
- Async reset while in FILL with `iwait` high:
  - Required: `iREN` drops immediately (no clock edge). Previously valid `0x40` misses after reset.
- Back-to-back sequential fetch `0x0, 0x4 … 0x3C` with `iwait = 0`:
  - First pass: every address misses with a 2-cycle penalty.
  - Second pass: 16 consecutive single-cycle hits with no `iREN`.
